// File: rtl/vga_pkg.sv
// vga_pkg: command opcodes, FIFO reader state encoding and 800x600 default timing.
package vga_pkg;
    typedef enum logic [1:0] {
        OP_RED   = 2'b00,
        OP_GREEN = 2'b01,
        OP_BLUE  = 2'b10,
        OP_MODE  = 2'b11
    } opcode_e;
    typedef enum logic [1:0] {RD_IDLE, RD_STROBE, RD_LATCH, RD_RECOVER} rd_state_e;
    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FRONT   = 40;
    localparam int DEF_H_SYNC    = 128;
    localparam int DEF_H_BACK    = 88;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FRONT   = 1;
    localparam int DEF_V_SYNC    = 4;
    localparam int DEF_V_BACK    = 23;
endpackage

// File: rtl/vga_fifo_reader.sv
// vga_fifo_reader: strobes an external FIFO with an active-low read and emits each byte with a 1-cycle valid.
module vga_fifo_reader
    import vga_pkg::*;
#(
    parameter int RD_ACCESS = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] disp_cmd_in,
    input  logic       nef_in,
    output logic       disp_cmd_rd,
    output logic [7:0] cmd_o,
    output logic       cmd_valid_o
);
    localparam int CW = $clog2(RD_ACCESS + 1);
    rd_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          rd_q, valid_q, nef_meta_q, nef_sync_q;
    logic [7:0]    cmd_q;
    // RECOVER spans the two-flop latency so a just-emptied FIFO is never re-strobed
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= RD_IDLE;
            cnt_q      <= '0;
            rd_q       <= 1'b1;
            valid_q    <= 1'b0;
            cmd_q      <= '0;
            nef_meta_q <= 1'b0;
            nef_sync_q <= 1'b0;
        end else begin
            {nef_sync_q, nef_meta_q} <= {nef_meta_q, nef_in};
            valid_q <= 1'b0;
            case (state_q)
                RD_IDLE: if (nef_sync_q) begin
                    state_q <= RD_STROBE;
                    rd_q    <= 1'b0;
                    cnt_q   <= '0;
                end
                RD_STROBE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(RD_ACCESS - 1)) state_q <= RD_LATCH;
                end
                RD_LATCH: begin
                    cmd_q   <= disp_cmd_in;
                    valid_q <= 1'b1;
                    rd_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= RD_RECOVER;
                end
                RD_RECOVER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(1)) state_q <= RD_IDLE;
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end
    assign disp_cmd_rd = rd_q;
    assign cmd_o       = cmd_q;
    assign cmd_valid_o = valid_q;
endmodule

// File: rtl/vga_cmd_timing.sv
// vga_cmd_timing: VGA sync/colour generator driven by byte commands from an external FIFO.
// Define VGA_GRADIENT_EN to compile in the gradient colour mode (opcode 11).
module vga_cmd_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int TICK_DIV  = 4,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int COLOR_W   = 4,
    parameter int RD_ACCESS = 3
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [7:0]         disp_cmd_in,
    input  logic               nef_in,
    output logic               disp_cmd_rd,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [TW-1:0]             tick_q, tick_d;
    logic [HW-1:0]             h_q, h_d;
    logic [VW-1:0]             v_q, v_d;
    logic                      pix_stb, h_last, v_last, hs_q, vs_q, fs_q, visible, cmd_valid;
    logic [2:0][COLOR_W-1:0]   pend_q, act_q, rgb_q, rgb_d;
    logic [COLOR_W-1:0]        grad_mask;
    logic [7:0]                cmd;
    logic                      unused_cmd;
    vga_fifo_reader #(.RD_ACCESS(RD_ACCESS)) u_reader (
        .clk         (clk),
        .nrst        (nrst),
        .disp_cmd_in (disp_cmd_in),
        .nef_in      (nef_in),
        .disp_cmd_rd (disp_cmd_rd),
        .cmd_o       (cmd),
        .cmd_valid_o (cmd_valid)
    );
    assign unused_cmd = ^cmd;
    assign pix_stb = tick_q == TW'(TICK_DIV - 1);
    assign h_last  = h_q == HW'(H_TOTAL - 1);
    assign v_last  = v_q == VW'(V_TOTAL - 1);
    assign visible = h_q < HW'(H_VISIBLE) && v_q < VW'(V_VISIBLE);
    always_comb begin
        tick_d = pix_stb ? '0 : tick_q + 1'b1;
        h_d    = !pix_stb ? h_q : h_last ? '0 : h_q + 1'b1;
        v_d    = !(pix_stb && h_last) ? v_q : v_last ? '0 : v_q + 1'b1;
        rgb_d  = visible ? act_q & {3{grad_mask}} : '0;
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_q <= '0;
            h_q    <= '0;
            v_q    <= '0;
            hs_q   <= ~HSYNC_POL;
            vs_q   <= ~VSYNC_POL;
            rgb_q  <= '0;
            fs_q   <= 1'b0;
        end else begin
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
            fs_q   <= pix_stb && h_last && v_last;
            if (pix_stb) begin
                hs_q  <= (h_q >= HW'(H_VISIBLE + H_FRONT) && h_q <= HW'(H_VISIBLE + H_FRONT + H_SYNC - 1)) ? HSYNC_POL : ~HSYNC_POL;
                vs_q  <= (v_q >= VW'(V_VISIBLE + V_FRONT) && v_q <= VW'(V_VISIBLE + V_FRONT + V_SYNC - 1)) ? VSYNC_POL : ~VSYNC_POL;
                rgb_q <= rgb_d;
            end
        end
    end
    // Colour opcodes 00/01/10 double as the channel index; a write in the frame_start cycle lands next frame
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            if (fs_q) act_q <= pend_q;
            if (cmd_valid && cmd[7:6] != OP_MODE) pend_q[cmd[7:6]] <= cmd[COLOR_W-1:0];
        end
    end
`ifdef VGA_GRADIENT_EN
    logic                 pend_mode_q, act_mode_q;
    logic [COLOR_W+4:0]   h_wide;
    assign h_wide    = (COLOR_W + 5)'(h_q);
    assign grad_mask = act_mode_q ? COLOR_W'(h_wide >> 5) : '1;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_mode_q <= 1'b0;
            act_mode_q  <= 1'b0;
        end else begin
            if (fs_q) act_mode_q <= pend_mode_q;
            if (cmd_valid && cmd[7:6] == OP_MODE) pend_mode_q <= cmd[0];
        end
    end
`else
    assign grad_mask = '1;
`endif
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign red         = rgb_q[0];
    assign green       = rgb_q[1];
    assign blue        = rgb_q[2];
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_cmd_timing.sv
// tb_vga_cmd_timing: small-timing bench (H 8/2/3/2, V 4/1/2/1, TICK_DIV 2, RD_ACCESS 3) with a FIFO model.
module tb_vga_cmd_timing;
    typedef struct {int k; int hs; int vs; int vis;} vec_t;
    typedef struct {int k; int hs; int vs; int r; int g; int b;} exp_t;
`ifdef VGA_GRADIENT_EN
    localparam bit GRAD = 1'b1;
`else
    localparam bit GRAD = 1'b0;
`endif
    logic       clk = 1'b0, nrst = 1'b1, nef_in = 1'b0;
    logic [7:0] disp_cmd_in = 8'h00;
    logic       disp_cmd_rd, hsync, vsync, frame_start;
    logic [3:0] red, green, blue;
    int         n_checks = 0, n_fails = 0, cyc = 0;
    logic [7:0] fifo[$];
    vec_t       vecs[14];
    exp_t       sb[$];

    always #5 clk = ~clk;

    vga_cmd_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .TICK_DIV(2), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_W(4), .RD_ACCESS(3)
    ) dut (
        .clk(clk), .nrst(nrst), .disp_cmd_in(disp_cmd_in), .nef_in(nef_in),
        .disp_cmd_rd(disp_cmd_rd), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .frame_start(frame_start)
    );

    // FIFO model: head byte is presented while non-empty, popped when the read strobe rises
    initial begin
        logic rd_prev;
        rd_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rd_prev && disp_cmd_rd && fifo.size() != 0) void'(fifo.pop_front());
            rd_prev     = disp_cmd_rd;
            nef_in      = fifo.size() != 0;
            disp_cmd_in = fifo.size() != 0 ? fifo[0] : 8'h00;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!frame_start && n < 300);
        check("frame_start_seen", frame_start, 1);
        cyc = 0;
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int   hs_n, vs_n, fs_n, fs_at, lows, n;
        int   rises[$], falls[$];
        logic prev;
        exp_t e;
        vecs = '{'{0, 0, 0, 0}, '{2, 0, 0, 1}, '{17, 0, 0, 1}, '{18, 0, 0, 0}, '{22, 1, 0, 0},
                 '{27, 1, 0, 0}, '{28, 0, 0, 0}, '{32, 0, 0, 1}, '{100, 0, 0, 1}, '{118, 0, 0, 0},
                 '{122, 0, 0, 0}, '{152, 0, 1, 0}, '{211, 0, 1, 0}, '{212, 0, 0, 0}};
        #1 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", disp_cmd_rd, 1);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_rgb", {red, green, blue}, 0);
        check("rst_fs", frame_start, 0);
        @(negedge clk) nrst = 1'b1;

        // free-running timing over one whole frame
        wait_fs();
        hs_n = 0; vs_n = 0; fs_n = 0; fs_at = -1;
        prev = hsync;
        for (int c = 1; c <= 240; c++) begin
            @(posedge clk); #1;
            if (hsync && !prev) rises.push_back(c);
            prev = hsync;
            hs_n += int'(hsync);
            vs_n += int'(vsync);
            if (frame_start) begin
                fs_n++;
                fs_at = c;
            end
        end
        cyc = 0;
        check("fs_count", fs_n, 1);
        check("frame_period", fs_at, 240);
        check("hsync_clks", hs_n, 48);
        check("vsync_clks", vs_n, 60);
        check("hsync_lines", rises.size(), 8);
        check("hsync_first", rises.size() > 1 ? rises[0] : -1, 22);
        check("line_period", rises.size() > 1 ? rises[1] - rises[0] : -1, 30);

        // colour bytes mid-frame take effect only after the next frame_start
        goto(50);
        fifo.push_back(8'h0F);
        fifo.push_back(8'h4A);
        fifo.push_back(8'h83);
        goto(100);
        check("cmd_drained", fifo.size(), 0);
        check("pre_frame_rgb", {red, green, blue}, 0);
        wait_fs();
        foreach (vecs[i]) begin
            sb.push_back('{vecs[i].k, vecs[i].hs, vecs[i].vs,
                           vecs[i].vis != 0 ? 15 : 0, vecs[i].vis != 0 ? 10 : 0, vecs[i].vis != 0 ? 3 : 0});
            goto(vecs[i].k);
            e = sb.pop_front();
            check($sformatf("k%0d_hsync", e.k), hsync, e.hs);
            check($sformatf("k%0d_vsync", e.k), vsync, e.vs);
            check($sformatf("k%0d_red", e.k), red, e.r);
            check($sformatf("k%0d_green", e.k), green, e.g);
            check($sformatf("k%0d_blue", e.k), blue, e.b);
        end

        // back-to-back reads: strobe width and byte period
        fifo.push_back(8'h0F);
        fifo.push_back(8'h4A);
        fifo.push_back(8'h83);
        lows = 0;
        prev = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (prev && !disp_cmd_rd) falls.push_back(c);
            lows += int'(!disp_cmd_rd);
            prev = disp_cmd_rd;
        end
        check("rd_strobes", falls.size(), 3);
        check("rd_low_clks", lows, 12);
        check("byte_period_1", falls.size() > 2 ? falls[1] - falls[0] : -1, 7);
        check("byte_period_2", falls.size() > 2 ? falls[2] - falls[1] : -1, 7);

        // mode opcode: gradient masks by hcount[8:5] (zero here), otherwise consumed and ignored
        fifo.push_back(8'hC1);
        repeat (20) @(posedge clk);
        #1;
        check("mode_drained", fifo.size(), 0);
        wait_fs();
        goto(100);
        check("mode_red", red, GRAD ? 0 : 15);
        check("mode_green", green, GRAD ? 0 : 10);

        // reset mid-strobe releases the strobe at once and latches nothing
        fifo.push_back(8'h05);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (disp_cmd_rd && n < 50);
        check("strobe_seen", disp_cmd_rd, 0);
        #2 nrst = 1'b0;
        fifo.delete();
        #1 check("rst_async_rd", disp_cmd_rd, 1);
        @(negedge clk);
        @(negedge clk) nrst = 1'b1;
        wait_fs();
        goto(100);
        check("post_rst_red_f1", red, 0);
        check("post_rst_rd_idle", disp_cmd_rd, 1);
        wait_fs();
        goto(100);
        check("post_rst_red_f2", red, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
